// File: rtl/mt_untemper.sv
// mt_untemper: iterative inverse of MT19937 output tempering with valid/ready on both sides.
// Optional re-temper self-check enabled by defining MT_UNTEMPER_CHECK_EN. Rev 1.0
`default_nettype none

module mt_untemper #(
  parameter int          N = 624,
  parameter int          U = 11,
  parameter logic [31:0] D = 32'hFFFFFFFF,
  parameter int          S = 7,
  parameter logic [31:0] B = 32'h9D2C5680,
  parameter int          T = 15,
  parameter logic [31:0] C = 32'hEFC60000,
  parameter int          L = 18,
  localparam int         IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [31:0]   in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [31:0]   out_data,
  output logic [IW-1:0] out_index,
  output logic          state_full,
  output logic          mismatch
);

  localparam int CW = 6;
  // Last iteration index of each stage: ceil(32/shift) - 1.
  localparam logic [CW-1:0] KM_L = CW'((32 + L - 1) / L - 1);
  localparam logic [CW-1:0] KM_T = CW'((32 + T - 1) / T - 1);
  localparam logic [CW-1:0] KM_S = CW'((32 + S - 1) / S - 1);
  localparam logic [CW-1:0] KM_U = CW'((32 + U - 1) / U - 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    UL   = 3'd1,
    UT   = 3'd2,
    US   = 3'd3,
    UU   = 3'd4,
    OUT  = 3'd5
  } state_t;

  state_t          state_q, state_d;
  logic [31:0]     x_q, x_d;
  logic [31:0]     y_q, y_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            full_q, full_d;

  logic [31:0]     w_stage_x;
  logic            w_last;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      full_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      full_q  <= full_d;
    end
  end

  // One fixed-point iteration of the active undo stage; y holds the stage input.
  always_comb begin
    w_stage_x = x_q;
    w_last    = 1'b0;
    unique case (state_q)
      UL: begin
        w_stage_x = y_q ^ (x_q >> L);
        w_last    = (cnt_q == KM_L);
      end
      UT: begin
        w_stage_x = y_q ^ ((x_q << T) & C);
        w_last    = (cnt_q == KM_T);
      end
      US: begin
        w_stage_x = y_q ^ ((x_q << S) & B);
        w_last    = (cnt_q == KM_S);
      end
      UU: begin
        w_stage_x = y_q ^ ((x_q >> U) & D);
        w_last    = (cnt_q == KM_U);
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    full_d  = full_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          x_d     = in_data;
          y_d     = in_data;
          cnt_d   = '0;
          state_d = UL;
        end
      end
      UL, UT, US, UU: begin
        x_d = w_stage_x;
        if (w_last) begin
          // The stage result becomes the next stage's target and its seed.
          y_d   = w_stage_x;
          cnt_d = '0;
          unique case (state_q)
            UL:      state_d = UT;
            UT:      state_d = US;
            US:      state_d = UU;
            default: state_d = OUT;
          endcase
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      OUT: begin
        if (out_ready) begin
          state_d = IDLE;
          if (idx_q == IW'(N - 1)) begin
            idx_d  = '0;
            full_d = 1'b1;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready   = (state_q == IDLE);
  assign out_valid  = (state_q == OUT);
  assign out_data   = x_q;
  assign out_index  = idx_q;
  assign state_full = full_q;

`ifdef MT_UNTEMPER_CHECK_EN
  logic [31:0] tin_q;
  logic        mismatch_q;
  logic [31:0] w_retemp;

  always_comb begin
    w_retemp = x_q;
    w_retemp = w_retemp ^ ((w_retemp >> U) & D);
    w_retemp = w_retemp ^ ((w_retemp << S) & B);
    w_retemp = w_retemp ^ ((w_retemp << T) & C);
    w_retemp = w_retemp ^ (w_retemp >> L);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tin_q      <= '0;
      mismatch_q <= 1'b0;
    end else begin
      if (state_q == IDLE && in_valid) begin
        tin_q <= in_data;
      end
      if (state_q == OUT && w_retemp != tin_q) begin
        mismatch_q <= 1'b1;
      end
    end
  end

  assign mismatch = mismatch_q;
`else
  assign mismatch = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mt_untemper.sv
// tb_mt_untemper: directed self-checking bench for mt_untemper (optional MT_UNTEMPER_CHECK_EN tests).
`default_nettype none

module tb_mt_untemper;

  localparam int N  = 624;
  localparam int IW = $clog2(N);

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [31:0]   in_data;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_data;
  logic [IW-1:0] out_index;
  logic          state_full;
  logic          mismatch;

  int n_assert = 0;
  int n_fail   = 0;

  mt_untemper dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_index  (out_index),
    .state_full (state_full),
    .mismatch   (mismatch)
  );

  always #5 clk = ~clk;

  // Forward MT19937 tempering, used to build inputs from known raw words.
  function automatic logic [31:0] temper(input logic [31:0] r);
    logic [31:0] y;
    y = r;
    y = y ^ (y >> 11);
    y = y ^ ((y << 7) & 32'h9D2C5680);
    y = y ^ ((y << 15) & 32'hEFC60000);
    y = y ^ (y >> 18);
    return y;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic accept(input logic [31:0] d);
    int k;
    in_data  = d;
    in_valid = 1'b1;
    k = 0;
    while (in_ready !== 1'b1 && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    check("accept_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input string tag);
    int lat;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    check(tag, lat, 32'd13);
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    logic        ok;
    logic [31:0] held;
    logic [31:0] r;
    logic        exp_full;
    int          exp_idx;

    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    check("rst_in_ready",   {31'd0, in_ready},   32'd1);
    check("rst_out_valid",  {31'd0, out_valid},  32'd0);
    check("rst_out_data",   out_data,            32'd0);
    check("rst_out_index",  32'(out_index),      32'd0);
    check("rst_state_full", {31'd0, state_full}, 32'd0);
    check("rst_mismatch",   {31'd0, mismatch},   32'd0);

    // Hand-computed vector: temper(1) = 0x00400091.
    accept(32'h00400091);
    wait_out("lat_a");
    check("data_a",  out_data,       32'h00000001);
    check("index_a", 32'(out_index), 32'd0);
    handshake();
    check("post_hs_out_valid", {31'd0, out_valid}, 32'd0);
    check("post_hs_in_ready",  {31'd0, in_ready},  32'd1);

    accept(32'h00000000);
    wait_out("lat_b");
    check("data_b",  out_data,       32'h00000000);
    check("index_b", 32'(out_index), 32'd1);

    // Stall in OUT with a new word pending on the input.
    held     = out_data;
    in_data  = temper(32'd5);
    in_valid = 1'b1;
    ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b1 || out_data !== held || in_ready !== 1'b0) ok = 1'b0;
    end
    check("stall_stable", {31'd0, ok}, 32'd1);
    handshake();
    check("stall_not_taken", {31'd0, in_ready}, 32'd1);
    accept(temper(32'd5));
    wait_out("lat_c");
    check("data_c",  out_data,       32'd5);
    check("index_c", 32'(out_index), 32'd2);
    handshake();

    // Full-state stream; index continues from 3 and wraps through 623.
    exp_full = 1'b0;
    exp_idx  = 3;
    for (int i = 0; i < N; i++) begin
      accept(temper(32'(i)));
      wait_out("lat_stream");
      check("stream_data",  out_data,       32'(i));
      check("stream_index", 32'(out_index), 32'(exp_idx));
      check("stream_full_pre", {31'd0, state_full}, {31'd0, exp_full});
      handshake();
      if (exp_idx == N - 1) begin
        exp_full = 1'b1;
        exp_idx  = 0;
      end else begin
        exp_idx++;
      end
      check("stream_full_post", {31'd0, state_full}, {31'd0, exp_full});
    end
    check("stream_end_index", 32'(out_index), 32'd3);

    // Reset sampled on iteration 2 of the US stage (edge 8 after acceptance).
    accept(temper(32'h12345678));
    repeat (7) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_in_ready",   {31'd0, in_ready},   32'd1);
    check("midrst_out_valid",  {31'd0, out_valid},  32'd0);
    check("midrst_out_index",  32'(out_index),      32'd0);
    check("midrst_state_full", {31'd0, state_full}, 32'd0);
    ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0) ok = 1'b0;
    end
    check("midrst_no_pulse", {31'd0, ok}, 32'd1);
    accept(temper(32'h89ABCDEF));
    wait_out("lat_after_rst");
    check("data_after_rst",  out_data,       32'h89ABCDEF);
    check("index_after_rst", 32'(out_index), 32'd0);
    handshake();

    for (int i = 0; i < 8; i++) begin
      r = $urandom;
      accept(temper(r));
      wait_out("lat_rand");
      check("rand_data",  out_data,       r);
      check("rand_index", 32'(out_index), 32'(i + 1));
      handshake();
    end
    check("rand_mismatch", {31'd0, mismatch}, 32'd0);

`ifdef MT_UNTEMPER_CHECK_EN
    accept(temper(32'hCAFEBABE));
    wait_out("lat_force");
    force dut.x_q = 32'h00000000;
    @(posedge clk); #1;
    release dut.x_q;
    check("force_mismatch", {31'd0, mismatch}, 32'd1);
    handshake();
    repeat (3) @(posedge clk);
    #1;
    check("force_sticky", {31'd0, mismatch}, 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("force_cleared", {31'd0, mismatch}, 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
